// File: rtl/fetchq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetchq_pkg
// Description : Shared types for the instruction-fetch prefetch queue:
//               fetch FSM state encoding and the queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetchq_pkg;

  // Reference instruction/PC width of the queue entry layout.
  localparam int FQ_DATA_W = 16;

  // Fetch FSM: nothing outstanding, one read outstanding, outstanding read
  // to be discarded when it completes.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } fq_state_t;

  // One buffered instruction: the word, its fetch PC + step and the error
  // flag returned with it.
  typedef struct packed {
    logic [FQ_DATA_W-1:0] inst;
    logic [FQ_DATA_W-1:0] pcplus;
    logic                 err;
  } fq_entry_t;

  // Flat storage width of one entry for a given instruction width.
  function automatic int fq_entry_bits(input int w);
    return (2 * w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetchq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetchq_fifo
// Description : DEPTH-entry synchronous FIFO with push, pop, flush and an
//               occupancy count. DEPTH must be a power of two so that the
//               pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetchq_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same edge, so push on full is legal
  // when paired with a pop.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != FULL_C) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end. Owns the PC, issues single
//               outstanding reads over the Rd/Done/Stall handshake and
//               buffers returned instructions with PC+step in a prefetch
//               queue drained by decode through valid/ready. Redirects flush
//               the queue and squash an in-flight read.
//               Optional build macro FETCHQ_BYPASS_EN: an empty queue
//               forwards a completing read straight to the decode outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              hold,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] pcplus,
  output logic              inst_err,
  output logic              imem_rd,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_done,
  input  logic              imem_stall,
  input  logic              imem_err
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam int                ENT_W   = fq_entry_bits(DATA_W);
  localparam logic [DATA_W-1:0] STEP_C  = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] RST_PC  = DATA_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fq_state_t         state;
  logic [DATA_W-1:0] pc;
  logic              halt;

  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head;
  logic [ENT_W-1:0]  push_entry;
  logic              has_space;
  logic              accept;
  logic              complete;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] done_pcplus;

  assign imem_addr = pc;

  // Space check: in WAIT the outstanding read already owns one slot, so a
  // follow-on issue in its completion cycle needs a second free slot.
  always_comb begin
    has_space = 1'b0;
    case (state)
      ST_IDLE: has_space = (fifo_count < DEPTH_C);
      ST_WAIT: has_space = imem_done && (fifo_count < (DEPTH_C - 1'b1));
      default: has_space = 1'b0;
    endcase
  end

  assign imem_rd = !rst && !halt && !hold && !redirect && has_space;
  assign accept  = imem_rd && !imem_stall;

  // A live read completes either as a hit in its acceptance cycle or later
  // while waiting; completions in SQUASH or stray ones in IDLE are ignored.
  assign complete = imem_done &&
                    ((state == ST_WAIT) || ((state == ST_IDLE) && accept));

  // While waiting the PC has already moved past the outstanding read, so
  // it equals that read's PC + step; a hit has not advanced it yet.
  assign done_pcplus = (state == ST_WAIT) ? pc : (pc + STEP_C);
  assign push_entry  = {imem_data, done_pcplus, imem_err};

`ifdef FETCHQ_BYPASS_EN
  assign bypass = complete && !redirect && (fifo_count == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed by decode in the same cycle is never stored.
  assign push = complete && !redirect && !rst && !(bypass && inst_ready);
  assign pop  = inst_ready && (fifo_count != '0) && !redirect;

  fetchq_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count)
  );

  // Decode-facing head view: zero when empty, forwarded data when bypassing.
  always_comb begin
    inst_valid = (fifo_count != '0);
    inst       = '0;
    pcplus     = '0;
    inst_err   = 1'b0;
    if (inst_valid) begin
      {inst, pcplus, inst_err} = head;
    end
    if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_data;
      pcplus     = done_pcplus;
      inst_err   = imem_err;
    end
  end

  // Fetch FSM with PC and error-halt registers; redirect overrides any
  // simultaneous completion, pop or acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RST_PC;
      halt  <= 1'b0;
    end else if (redirect) begin
      pc   <= redirect_pc;
      halt <= 1'b0;
      // A read still in flight must be discarded when it returns; one that
      // completes right now is simply dropped.
      if ((state != ST_IDLE) && !imem_done) state <= ST_SQUASH;
      else                                  state <= ST_IDLE;
    end else begin
      if (accept) pc <= pc + STEP_C;
      if (complete && imem_err) halt <= 1'b1;
      case (state)
        ST_IDLE:   if (accept && !imem_done) state <= ST_WAIT;
        ST_WAIT:   if (imem_done && !accept) state <= ST_IDLE;
        ST_SQUASH: if (imem_done)            state <= ST_IDLE;
        default:                             state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
